cpu_run_monitor: RTL and testbench

Synthesizable run monitor for the single-cycle CPU that replaces bench-side end-of-program detection. Watches the retiring PC, counts executed cycles and detects program end by end address, self-loop, timeout or external request. Then freezes the CPU and streams the architectural register file plus the final cycle count out over a valid/ready port. Sits beside the top-level CPU, using the register file's read port and the PC.

---
 rtl/cpu_run_monitor.sv | 153 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle CPU: counts executed cycles and detects program end.
// After a halt it freezes the CPU and streams the register file plus the cycle count out.
module cpu_run_monitor #(
    parameter int              XLEN         = 64,
    parameter int              NREG         = 32,
    parameter int              REG_AW       = 5,
    parameter longint unsigned END_PC       = 60,
    parameter int              STABLE_LIMIT = 8,
    parameter int              MAX_CYCLES   = 100000,
    parameter int              CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    input  logic              pc_valid,
    input  logic              halt_req,
    output logic              cpu_stall,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              dump_valid,
    output logic [XLEN-1:0]   dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done
);

    localparam int                SW         = $clog2(STABLE_LIMIT + 1);
    localparam logic [XLEN-1:0]   LP_END_PC  = XLEN'(END_PC);
    localparam logic [CNT_W-1:0]  LP_MAX     = CNT_W'(MAX_CYCLES);
    localparam logic [SW-1:0]     LP_STABLE  = SW'(STABLE_LIMIT);
    localparam logic [REG_AW-1:0] LP_LASTREG = REG_AW'(NREG - 1);

    typedef enum logic [1:0] {
        RUN,
        DUMP_REG,
        DUMP_CNT,
        DONE
    } stateT;

    stateT             r_state;
    stateT             w_nextState;

    logic [CNT_W-1:0]  r_cycleCount;
    logic [2:0]        r_haltCause;
    logic [REG_AW-1:0] r_idx;
    logic [XLEN-1:0]   r_prevPc;
    logic              r_prevVld;
    logic [SW-1:0]     r_stableCnt;

    logic [CNT_W-1:0]  w_countInc;
    logic [SW-1:0]     w_stableNext;
    logic              w_haltEnd;
    logic              w_haltLoop;
    logic              w_haltTime;
    logic              w_halt;
    logic [2:0]        w_cause;
    logic              w_xfer;
    logic              w_lastReg;

    // Halt detection for the current cycle; the counter saturates instead of wrapping.
    always_comb begin
        w_countInc   = (r_cycleCount == '1) ? r_cycleCount : r_cycleCount + CNT_W'(1);
        w_stableNext = (r_prevVld && (pc == r_prevPc)) ? r_stableCnt + SW'(1) : '0;
        w_haltEnd    = pc_valid && (pc >= LP_END_PC);
        w_haltLoop   = pc_valid && (w_stableNext == LP_STABLE);
        w_haltTime   = pc_valid && (w_countInc == LP_MAX);
        w_halt       = halt_req || w_haltEnd || w_haltLoop || w_haltTime;
        w_cause      = 3'd0;
        if (halt_req) begin
            w_cause = 3'd4;
        end else if (w_haltEnd) begin
            w_cause = 3'd1;
        end else if (w_haltLoop) begin
            w_cause = 3'd2;
        end else if (w_haltTime) begin
            w_cause = 3'd3;
        end
        w_xfer    = dump_ready && ((r_state == DUMP_REG) || (r_state == DUMP_CNT));
        w_lastReg = (r_idx == LP_LASTREG);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:      if (w_halt) w_nextState = DUMP_REG;
            DUMP_REG: if (w_xfer && w_lastReg) w_nextState = DUMP_CNT;
            DUMP_CNT: if (w_xfer) w_nextState = DONE;
            DONE:     w_nextState = DONE;
            default:  w_nextState = RUN;
        endcase
    end

    // Monitor state only moves in RUN; the dump index only advances on an accepted word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cycleCount <= '0;
            r_haltCause  <= '0;
            r_idx        <= '0;
            r_prevPc     <= '0;
            r_prevVld    <= 1'b0;
            r_stableCnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (pc_valid) begin
                        r_cycleCount <= w_countInc;
                        r_prevPc     <= pc;
                        r_prevVld    <= 1'b1;
                        r_stableCnt  <= w_stableNext;
                    end
                    if (w_halt) begin
                        r_haltCause <= w_cause;
                        r_idx       <= '0;
                    end
                end
                DUMP_REG: begin
                    if (w_xfer && !w_lastReg) begin
                        r_idx <= r_idx + REG_AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cpu_stall   = (r_state != RUN);
        dump_valid  = (r_state == DUMP_REG) || (r_state == DUMP_CNT);
        dump_last   = (r_state == DUMP_CNT);
        done        = (r_state == DONE);
        rf_raddr    = r_idx;
        halt_cause  = r_haltCause;
        cycle_count = r_cycleCount;
        dump_data   = '0;
        case (r_state)
            DUMP_REG: dump_data = rf_rdata;
            DUMP_CNT: dump_data = XLEN'(r_cycleCount);
            default:  dump_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed and random programs checked against a
// queue-based model of halt detection and the expected dump word sequence.
module tb_cpu_run_monitor;

    localparam int NREG  = 32;
    localparam int ENDPC = 60;
    localparam int LIMIT = 8;
    localparam int MAXC  = 50;

    logic        clk;
    logic        reset;
    logic [63:0] pc;
    logic        pc_valid;
    logic        halt_req;
    logic        cpu_stall;
    logic [4:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic        dump_valid;
    logic [63:0] dump_data;
    logic        dump_last;
    logic        dump_ready;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_count;
    logic        done;

    logic [63:0] rfMem [NREG];
    int          checks;
    int          failures;

    int          mCount;
    int          mCause;
    bit          mHalted;
    logic [63:0] validHist [$];

    logic [63:0] curPc;
    logic [63:0] nextPc;
    logic [31:0] savedCount;
    logic        v;
    logic        h;
    int          sel;
    int          j;

    cpu_run_monitor #(
        .XLEN(64), .NREG(NREG), .REG_AW(5), .END_PC(ENDPC),
        .STABLE_LIMIT(LIMIT), .MAX_CYCLES(MAXC), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .halt_req(halt_req),
        .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
        .dump_ready(dump_ready), .halt_cause(halt_cause), .cycle_count(cycle_count),
        .done(done)
    );

    assign rf_rdata = rfMem[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // A self-loop is the last LIMIT+1 executed PCs since reset all being identical.
    function automatic bit loopDetected();
        int n;
        n = validHist.size();
        if (n < LIMIT + 1) return 1'b0;
        for (int i = n - LIMIT; i < n; i++) begin
            if (validHist[i] != validHist[n - 1 - LIMIT]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] expWord(input int k);
        if (k < NREG) return rfMem[k];
        return 64'(mCount);
    endfunction

    task automatic doReset();
        reset      = 1'b0;
        pc_valid   = 1'b0;
        halt_req   = 1'b0;
        dump_ready = 1'b0;
        pc         = '0;
        @(posedge clk); #1;
        mCount  = 0;
        mCause  = 0;
        mHalted = 1'b0;
        validHist.delete();
        checkOutput("rst_cycle_count", 64'(cycle_count), 64'd0);
        checkOutput("rst_halt_cause", 64'(halt_cause), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_dump_valid", 64'(dump_valid), 64'd0);
        checkOutput("rst_dump_last", 64'(dump_last), 64'd0);
        checkOutput("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        checkOutput("rst_rf_raddr", 64'(rf_raddr), 64'd0);
        checkOutput("rst_dump_data", dump_data, 64'd0);
        reset = 1'b1;
    endtask

    // One CPU cycle: drive, update the model, clock, then compare.
    task automatic applyStimulus(input logic [63:0] pcIn, input logic vIn, input logic hIn);
        int cause;
        pc       = pcIn;
        pc_valid = vIn;
        halt_req = hIn;
        cause    = 0;
        if (vIn) begin
            validHist.push_back(pcIn);
            mCount++;
        end
        if (hIn) cause = 4;
        else if (vIn && (pcIn >= 64'(ENDPC))) cause = 1;
        else if (vIn && loopDetected()) cause = 2;
        else if (vIn && (mCount == MAXC)) cause = 3;
        if (cause != 0) begin
            mCause  = cause;
            mHalted = 1'b1;
        end
        @(posedge clk); #1;
        pc_valid = 1'b0;
        halt_req = 1'b0;
        checkOutput("run_cpu_stall", 64'(cpu_stall), 64'(mHalted));
        checkOutput("run_dump_valid", 64'(dump_valid), 64'(mHalted));
        checkOutput("run_cycle_count", 64'(cycle_count), 64'(mCount));
        checkOutput("run_halt_cause", 64'(halt_cause), 64'(mCause));
    endtask

    // mode 0: always ready, 1: low 5 cycles at idx 7 then toggling, 2: random.
    task automatic dumpPhase(input int mode, input int abortAt);
        int k;
        int cycles;
        int phase;
        int lowCnt;
        bit tog;
        bit ready;
        k = 0; cycles = 0; phase = 0; lowCnt = 0; tog = 1'b0; ready = 1'b0;
        while (k <= NREG && cycles < 400) begin
            if (k == abortAt) begin
                checkOutput("abort_raddr", 64'(rf_raddr), 64'(k));
                return;
            end
            if (mode == 0) begin
                ready = 1'b1;
            end else if (mode == 1) begin
                if (phase == 0 && k == 7) phase = 1;
                if (phase == 0) begin
                    ready = 1'b1;
                end else if (phase == 1) begin
                    ready = 1'b0;
                    lowCnt++;
                    if (lowCnt == 5) phase = 2;
                end else begin
                    ready = tog;
                    tog   = ~tog;
                end
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            dump_ready = ready;
            checkOutput("dump_valid", 64'(dump_valid), 64'd1);
            checkOutput("dump_cpu_stall", 64'(cpu_stall), 64'd1);
            checkOutput("dump_last", 64'(dump_last), 64'(k == NREG));
            if (k < NREG) checkOutput("dump_raddr", 64'(rf_raddr), 64'(k));
            checkOutput("dump_data", dump_data, expWord(k));
            if (ready) k++;
            @(posedge clk); #1;
            cycles++;
        end
        dump_ready = 1'b0;
        checkOutput("dump_words", 64'(k), 64'(NREG + 1));
        checkOutput("done_after_dump", 64'(done), 64'd1);
        checkOutput("done_dump_valid", 64'(dump_valid), 64'd0);
        checkOutput("done_dump_data", dump_data, 64'd0);
        checkOutput("done_dump_last", 64'(dump_last), 64'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        pc         = '0;
        pc_valid   = 1'b0;
        halt_req   = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < NREG; i++) rfMem[i] = 64'(i) * 64'h1111;
        @(posedge clk); #1;
        doReset();

        $display("[TB] end-PC program");
        for (int c = 0; c < 100 && !mHalted; c++) applyStimulus(64'(c * 4), 1'b1, 1'b0);
        checkOutput("endpc_cause", 64'(halt_cause), 64'd1);
        checkOutput("endpc_count", 64'(cycle_count), 64'd16);
        dumpPhase(0, -1);

        $display("[TB] self-loop program with idle cycles");
        doReset();
        j = 0;
        for (int c = 0; c < 200 && !mHalted; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus({$urandom, $urandom}, 1'b0, 1'b0);
            end else begin
                applyStimulus((j < 9) ? 64'(j * 4) : 64'h20, 1'b1, 1'b0);
                j++;
            end
        end
        checkOutput("loop_cause", 64'(halt_cause), 64'd2);
        checkOutput("loop_count", 64'(cycle_count), 64'd17);
        dumpPhase(0, -1);

        $display("[TB] timeout program");
        doReset();
        for (int i = 0; i < NREG; i++) rfMem[i] = {$urandom, $urandom};
        for (int c = 0; c < 100 && !mHalted; c++) applyStimulus(64'((c % 15) * 4), 1'b1, 1'b0);
        checkOutput("timeout_cause", 64'(halt_cause), 64'd3);
        checkOutput("timeout_count", 64'(cycle_count), 64'd50);
        dumpPhase(2, -1);

        $display("[TB] external halt with backpressure");
        doReset();
        for (int i = 0; i < NREG; i++) rfMem[i] = {$urandom, $urandom};
        for (int c = 0; c < 15; c++) applyStimulus(64'(c * 4), 1'b1, 1'b0);
        applyStimulus(64'd60, 1'b1, 1'b1);
        checkOutput("ext_cause", 64'(halt_cause), 64'd4);
        checkOutput("ext_count", 64'(cycle_count), 64'd16);
        dumpPhase(1, -1);

        $display("[TB] random programs");
        for (int r = 0; r < 8; r++) begin
            doReset();
            for (int i = 0; i < NREG; i++) rfMem[i] = {$urandom, $urandom};
            curPc = '0;
            for (int c = 0; c < 300 && !mHalted; c++) begin
                v   = ($urandom_range(0, 3) != 0);
                h   = ($urandom_range(0, 59) == 0);
                sel = int'($urandom_range(0, 99));
                if (sel < 55) nextPc = curPc;
                else if (sel < 97) nextPc = 64'($urandom_range(0, 14)) * 64'd4;
                else nextPc = 64'd60 + 64'($urandom_range(0, 100));
                if (v) begin
                    curPc = nextPc;
                    applyStimulus(nextPc, 1'b1, h);
                end else begin
                    applyStimulus({$urandom, $urandom}, 1'b0, h);
                end
            end
            checkOutput("rand_halted", 64'(cpu_stall), 64'd1);
            dumpPhase(2, -1);
        end

        $display("[TB] reset during dump");
        doReset();
        for (int i = 0; i < NREG; i++) rfMem[i] = {$urandom, $urandom};
        for (int c = 0; c < 100 && !mHalted; c++) applyStimulus(64'(c * 4), 1'b1, 1'b0);
        dumpPhase(0, 10);
        doReset();
        for (int c = 0; c < 100 && !mHalted; c++) applyStimulus(64'(c * 4 + 8), 1'b1, 1'b0);
        checkOutput("rerun_cause", 64'(halt_cause), 64'd1);
        checkOutput("rerun_count", 64'(cycle_count), 64'd14);
        dumpPhase(0, -1);

        $display("[TB] inputs ignored after done");
        savedCount = cycle_count;
        for (int c = 0; c < 4; c++) begin
            pc       = '0;
            pc_valid = 1'b1;
            halt_req = 1'b1;
            @(posedge clk); #1;
            checkOutput("post_done", 64'(done), 64'd1);
            checkOutput("post_dump_valid", 64'(dump_valid), 64'd0);
            checkOutput("post_cpu_stall", 64'(cpu_stall), 64'd1);
            checkOutput("post_count", 64'(cycle_count), 64'(savedCount));
            checkOutput("post_cause", 64'(halt_cause), 64'd1);
        end
        pc_valid = 1'b0;
        halt_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
